// File: rtl/vga_read_timing_gen.sv
// VGA read-side timing generator: active-low syncs, lead-adjusted READ_Request window, blank flag, raw counters.
// All outputs are registered and decoded from next-state values, so each one lines up with the H_Cont/V_Cont it describes.
module vga_read_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int READ_LEAD = 2
) (
  input  logic        VGA_CLK,
  input  logic        RST,
  input  logic        iEN,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        READ_Request,
  output logic        oBLANK_N,
  output logic [11:0] H_Cont,
  output logic [12:0] V_Cont,
  output logic        oFRAME_START
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_END   = 12'(H_SYNC);
  localparam logic [11:0] HA_START = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] HA_END   = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [11:0] RD_START = 12'(H_SYNC + H_BACK - READ_LEAD);
  localparam logic [11:0] RD_END   = 12'(H_SYNC + H_BACK + H_ACTIVE - READ_LEAD);
  localparam logic [12:0] V_LAST   = 13'(V_TOTAL - 1);
  localparam logic [12:0] VS_END   = 13'(V_SYNC);
  localparam logic [12:0] VA_START = 13'(V_SYNC + V_BACK);
  localparam logic [12:0] VA_END   = 13'(V_SYNC + V_BACK + V_ACTIVE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic        live_q, live_d;
  logic [11:0] h_q, h_d;
  logic [12:0] v_q, v_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        rr_q, rr_d;
  logic        bl_q, bl_d;
  logic        fs_q, fs_d;
  logic        frame_last;
  logic        v_act;

  assign frame_last = (h_q == H_LAST) && (v_q == V_LAST);

  // live_q marks that the counters show a real raster position; the first RUN
  // clock after IDLE still shows idle values and loads (0,0) for the next one.
  always_comb begin
    state_d = state_q;
    live_d  = live_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE: begin
        live_d = 1'b0;
        h_d    = '0;
        v_d    = '0;
        if (iEN) state_d = S_RUN;
      end
      S_RUN, S_DRAIN: begin
        if (!live_q) begin
          live_d = 1'b1;
          h_d    = '0;
          v_d    = '0;
          if (state_q == S_RUN && !iEN) state_d = S_DRAIN;
        end else if (frame_last) begin
          h_d = '0;
          v_d = '0;
          if (state_q == S_DRAIN || !iEN) begin
            state_d = S_IDLE;
            live_d  = 1'b0;
          end
        end else begin
          if (h_q == H_LAST) begin
            h_d = '0;
            v_d = v_q + 13'd1;
          end else begin
            h_d = h_q + 12'd1;
          end
          if (state_q == S_RUN && !iEN) state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
        live_d  = 1'b0;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  always_comb begin
    hs_d  = 1'b1;
    vs_d  = 1'b1;
    rr_d  = 1'b0;
    bl_d  = 1'b0;
    fs_d  = 1'b0;
    v_act = (v_d >= VA_START) && (v_d < VA_END);
    if (live_d) begin
      hs_d = !(h_d < HS_END);
      vs_d = !(v_d < VS_END);
      bl_d = v_act && (h_d >= HA_START) && (h_d < HA_END);
      rr_d = v_act && (h_d >= RD_START) && (h_d < RD_END);
      fs_d = (h_d == '0) && (v_d == '0);
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      rr_q    <= 1'b0;
      bl_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rr_q    <= rr_d;
      bl_q    <= bl_d;
      fs_q    <= fs_d;
    end
  end

  assign VGA_HS       = hs_q;
  assign VGA_VS       = vs_q;
  assign READ_Request = rr_q;
  assign oBLANK_N     = bl_q;
  assign H_Cont       = h_q;
  assign V_Cont       = v_q;
  assign oFRAME_START = fs_q;

endmodule

// File: tb/tb_vga_read_timing_gen.sv
// Bench for vga_read_timing_gen at a shrunken raster (17 x 9 clocks/lines) with a second READ_LEAD=0 instance.
module tb_vga_read_timing_gen;

  localparam int HT = 17;
  localparam int VT = 9;
  localparam int FR = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en;
  logic        hs, vs, rr, bl, fs;
  logic [11:0] hc;
  logic [12:0] vc;
  logic        b_hs, b_vs, b_rr, b_bl, b_fs;
  logic [11:0] b_hc;
  logic [12:0] b_vc;

  vga_read_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .READ_LEAD(2)
  ) dut (
    .VGA_CLK(clk), .RST(rst), .iEN(en),
    .VGA_HS(hs), .VGA_VS(vs), .READ_Request(rr), .oBLANK_N(bl),
    .H_Cont(hc), .V_Cont(vc), .oFRAME_START(fs)
  );

  vga_read_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .READ_LEAD(0)
  ) dut_lead0 (
    .VGA_CLK(clk), .RST(rst), .iEN(en),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .READ_Request(b_rr), .oBLANK_N(b_bl),
    .H_Cont(b_hc), .V_Cont(b_vc), .oFRAME_START(b_fs)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        rr;
    logic        bl;
    logic        fs;
    logic [11:0] h;
    logic [12:0] v;
    logic        rr0;
  } vec_t;

  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference: mode 0 idle, 1 armed (enable seen, outputs still idle), 2 live at frame tick m_t
  int m_mode = 0;
  int m_t = 0;
  int m_drain = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t expect_vec(input int mode, input int t);
    vec_t e;
    int   h, v;
    logic vact;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (mode == 2) begin
      h    = t % HT;
      v    = t / HT;
      vact = (v >= 4) && (v < 8);
      e.h  = 12'(h);
      e.v  = 13'(v);
      e.hs = (h >= 3);
      e.vs = (v >= 2);
      e.bl = vact && (h >= 7) && (h < 15);
      e.rr = vact && (h >= 5) && (h < 13);
      e.rr0 = e.bl;
      e.fs = (t == 0);
    end
    return e;
  endfunction

  task automatic step_model(input logic r, input logic n);
    if (r) begin
      m_mode  = 0;
      m_drain = 0;
    end else begin
      case (m_mode)
        0: if (n) m_mode = 1;
        1: begin m_mode = 2; m_t = 0; m_drain = n ? 0 : 1; end
        default: begin
          if (m_t == FR - 1) begin
            if (m_drain != 0 || !n) begin m_mode = 0; m_drain = 0; end
            else m_t = 0;
          end else begin
            m_t++;
            if (!n) m_drain = 1;
          end
        end
      endcase
    end
  endtask

  task automatic tick(input logic r, input logic n);
    rst = r;
    en  = n;
    @(posedge clk);
    #1;
    step_model(r, n);
    exp_q.push_back(expect_vec(m_mode, m_t));
  endtask

  task automatic run_until(input int target, input int limit, input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < limit; i++) begin
      if (m_mode == 2 && m_t == target) begin hit = 1; break; end
      tick(1'b0, 1'b1);
    end
    chk(name, int'(hit), 1);
  endtask

  // Monitor: per-cycle scoreboard plus one-frame aggregate measurements
  vec_t act_v, exp_v;
  int   meas = 0;
  int   period, hs_low, vs_low, bl_high, rr_rises, rr_len;
  logic rr_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {hs, vs, rr, bl, fs, hc, vc, b_rr};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL cycle_vec at %0t actual hs=%b vs=%b rr=%b bl=%b fs=%b h=%0d v=%0d rr0=%b expected hs=%b vs=%b rr=%b bl=%b fs=%b h=%0d v=%0d rr0=%b",
                   $time, act_v.hs, act_v.vs, act_v.rr, act_v.bl, act_v.fs, act_v.h, act_v.v, act_v.rr0,
                   exp_v.hs, exp_v.vs, exp_v.rr, exp_v.bl, exp_v.fs, exp_v.h, exp_v.v, exp_v.rr0);
        end
        if (meas == 1 && fs === 1'b1) begin
          meas = 2;
          chk("frame_period", period, 153);
          chk("hs_low_clocks", hs_low, 27);
          chk("vs_low_clocks", vs_low, 34);
          chk("blank_n_high_clocks", bl_high, 32);
          chk("rr_pulses", rr_rises, 4);
        end else if (meas == 0 && fs === 1'b1) begin
          meas = 1;
          period = 0; hs_low = 0; vs_low = 0; bl_high = 0; rr_rises = 0; rr_len = 0;
        end
        if (meas == 1) begin
          period++;
          if (hs === 1'b0) hs_low++;
          if (vs === 1'b0) vs_low++;
          if (bl === 1'b1) bl_high++;
          if (rr === 1'b1 && rr_prev !== 1'b1) begin
            rr_rises++;
            chk("rr_rise_h", int'(hc), 5);
          end
          if (rr === 1'b1) rr_len++;
          if (rr !== 1'b1 && rr_prev === 1'b1) begin
            chk("rr_len", rr_len, 8);
            rr_len = 0;
          end
        end
        rr_prev = rr;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit idle_hit;
    rst = 1'b1;
    en  = 1'b1;
    repeat (5) tick(1'b1, 1'b1);
    // two uninterrupted frames, the first of which is measured
    repeat (2 * FR + 10) tick(1'b0, 1'b1);
    // drop enable mid-frame at line 5, finish frame, sit idle, restart
    run_until(5 * HT + 3, 400, "reach_drop_point");
    idle_hit = 0;
    for (int i = 0; i < 400; i++) begin
      tick(1'b0, 1'b0);
      if (m_mode == 0) begin idle_hit = 1; break; end
    end
    chk("drain_reaches_idle", int'(idle_hit), 1);
    repeat (10) tick(1'b0, 1'b0);
    repeat (200) tick(1'b0, 1'b1);
    // single-clock reset in the middle of a frame
    run_until(2 * HT + 6, 400, "reach_reset_point");
    tick(1'b1, 1'b1);
    repeat (200) tick(1'b0, 1'b1);
    // one-clock enable glitch inside a frame
    run_until(60, 400, "reach_toggle_point");
    tick(1'b0, 1'b0);
    repeat (3 * FR + 20) tick(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("frame_measured", meas, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_read_timing_gen.md
# vga_read_timing_gen

Timing generator that drives the VGA-side read interface consumed by the de-Bayer stage. It produces the active-low sync pair VGA_HS/VGA_VS, a READ_Request window that leads the visible pixels by a programmable number of clocks to cover line-buffer and de-Bayer latency, raw line and pixel counters, and a blanking flag. It sits between the VGA clock domain's PLL output and the RAW-to-RGB pipeline. A frame-boundary enable handshake keeps the stream from starting or stopping mid-frame.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal porch and sync widths, in clocks
- V_ACTIVE, 480: visible lines per frame
- V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical porch and sync widths, in lines
- READ_LEAD, 2: clocks by which READ_Request leads the visible window; legal range 0..H_SYNC+H_BACK
- VGA_CLK  in  1  sole clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- iEN  in  1  run request, sampled only at frame boundaries
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- READ_Request  out  1  high while the downstream pipeline must fetch pixels
- oBLANK_N  out  1  high during visible pixels
- H_Cont  out  12  pixel counter, 0..H_TOTAL-1
- V_Cont  out  13  line counter, 0..V_TOTAL-1
- oFRAME_START  out  1  one-clock pulse on the first clock of each frame

## Operation
- Derived constants:
  - H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (800).
  - HA_START = H_SYNC+H_BACK (144); HA_END = HA_START+H_ACTIVE (784).
  - V_TOTAL = 525; VA_START = V_SYNC+V_BACK (35); VA_END = VA_START+V_ACTIVE (515).
- Region order in each line and each frame: sync, back porch, active, front porch.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: counters held at 0, outputs idle. Move to RUN on the clock after iEN is sampled high.
  - RUN: counters advance. If iEN is low on the last clock of a frame (H_Cont = H_TOTAL-1, V_Cont = V_TOTAL-1), go to IDLE. If iEN goes low at any other point, go to DRAIN.
  - DRAIN: identical to RUN, but go to IDLE after the last clock of the frame. iEN reasserted during DRAIN is ignored; the FSM passes through IDLE for one clock before RUN.
- Counters:
  - H_Cont increments each clock in RUN/DRAIN and wraps from H_TOTAL-1 to 0.
  - V_Cont increments when H_Cont wraps and wraps from V_TOTAL-1 to 0.
- Decodes, all registered and aligned to the same clock as the H_Cont/V_Cont values they describe (decode from next-state values):
  - VGA_HS = 0 iff H_Cont < H_SYNC.
  - VGA_VS = 0 iff V_Cont < V_SYNC.
  - oBLANK_N = 1 iff HA_START ≤ H_Cont < HA_END and VA_START ≤ V_Cont < VA_END.
  - READ_Request = 1 iff HA_START-READ_LEAD ≤ H_Cont < HA_END-READ_LEAD and V_Cont is in the active range.
  - oFRAME_START = 1 iff H_Cont = 0 and V_Cont = 0 in RUN.
- Idle/reset output values: VGA_HS=1, VGA_VS=1, READ_Request=0, oBLANK_N=0, H_Cont=0, V_Cont=0, oFRAME_START=0, state IDLE.
- Reset has priority over everything, including mid-frame: all outputs take their idle values on the next clock.

## Timing
- RST high on edge k → idle outputs visible after edge k.
- iEN high sampled on edge k in IDLE → after edge k+1: H_Cont=0, V_Cont=0, VGA_HS=0, VGA_VS=0, oFRAME_START=1.
- HS period: H_TOTAL clocks, low for H_SYNC clocks.
- VS low for V_SYNC×H_TOTAL clocks; frame period H_TOTAL×V_TOTAL clocks.
- READ_Request: exactly H_ACTIVE clocks high per active line, exactly V_ACTIVE high pulses per frame, rising edge READ_LEAD clocks before oBLANK_N rises.
- No glitches: every output is a flop.
- Counter wrap: the clock after (H_TOTAL-1, V_TOTAL-1) shows (0,0), with no intermediate value.

## Test plan
- Reset: hold RST 5 clocks, iEN=1 → HS=VS=1, READ_Request=0, counters 0; one clock after release, H_Cont=0 and oFRAME_START=1.
- Full frame at default parameters → HS low 96 of every 800 clocks; VS low 1600 clocks; 480 READ_Request pulses of 640 clocks, each rising at H_Cont=142; oBLANK_N high 307200 clocks; next oFRAME_START 420000 clocks later.
- Set READ_LEAD=0 → READ_Request identical to oBLANK_N every clock for a whole frame.
- Drop iEN at V_Cont=200 → frame completes to (799,524), then IDLE with idle outputs; raising iEN 10 clocks later restarts at (0,0).
- Assert RST at V_Cont=100, H_Cont=300 for 1 clock → idle outputs on the next clock; no partial READ_Request pulse afterwards.
- Toggle iEN low/high within a single frame → FSM enters DRAIN, finishes the frame, spends one clock in IDLE, then restarts in RUN; frame count continues with no short frames.
